acc_datapath: RTL and testbench

- 16-bit accumulator (AH high byte, AL low byte) with an 8-bit ALU against BREG.
- Sits directly downstream of the instruction control block: it consumes that block's acc_* and op_* strobes, and feeds zero_flag and sign_flag back to it.
- Runs multi-cycle shift-add multiply and restoring divide under external step strobes.
- Drives AH onto the shared data bus.

---
 rtl/acc_datapath.sv | 175 +++++++++++++++++
 tb/tb_acc_datapath.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_datapath.sv
//==============================================================================
// Module      : acc_datapath
// Description : 16-bit accumulator (AH:AL) with an 8-bit ALU against BREG.
//               Supports externally sequenced shift-add multiply and
//               restoring divide. Drives AH onto the shared bus.
//               Optional macro ACC_OVF_FLAG_EN adds a registered signed
//               overflow flag for add/sub loads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acc_datapath #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] bus_in,
    input  logic [DW-1:0] breg_in,
    input  logic [1:0]    acc_high_select,
    input  logic [1:0]    acc_low_select,
    input  logic          acc_in_select,
    input  logic          acc_high_reset_p,
    input  logic          acc_oen,
    input  logic          op_add,
    input  logic          op_sub,
    input  logic          op_and,
    input  logic          op_mul,
    input  logic          op_div,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic [DW-1:0] acc_high,
    output logic [DW-1:0] acc_low,
    output logic          zero_flag,
    output logic          sign_flag
`ifdef ACC_OVF_FLAG_EN
    ,
    output logic          ovf_flag
`endif
);

    localparam logic [1:0] c_SEL_HOLD  = 2'b00;
    localparam logic [1:0] c_SEL_RIGHT = 2'b01;
    localparam logic [1:0] c_SEL_LEFT  = 2'b10;
    localparam logic [1:0] c_SEL_LOAD  = 2'b11;

    logic [DW-1:0] r_ah;
    logic [DW-1:0] r_al;
    logic          r_carry;
    logic          r_mul_last;

    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_alu_res;
    logic          w_carry_nxt;
    logic          w_div_op;
    logic          w_div_bit;
    logic [DW-1:0] w_ah_nxt;
    logic [DW-1:0] w_al_nxt;

    assign w_sum  = {1'b0, r_ah} + {1'b0, breg_in};
    assign w_diff = {1'b0, r_ah} - {1'b0, breg_in};

    // ALU: one operation per cycle, add > sub > and > mul > div
    always_comb begin
        w_alu_res   = r_ah;
        w_carry_nxt = r_carry;
        w_div_op    = 1'b0;
        w_div_bit   = 1'b0;
        if (op_add) begin
            w_alu_res   = w_sum[DW-1:0];
            w_carry_nxt = w_sum[DW];
        end else if (op_sub) begin
            w_alu_res   = w_diff[DW-1:0];
            w_carry_nxt = w_diff[DW];
        end else if (op_and) begin
            w_alu_res   = r_ah & breg_in;
        end else if (op_mul) begin
            if (r_al[0]) begin
                w_alu_res   = w_sum[DW-1:0];
                w_carry_nxt = w_sum[DW];
            end else begin
                w_carry_nxt = 1'b0;
            end
        end else if (op_div) begin
            // No borrow means AH >= B; B = 0 always takes this branch
            w_div_op = 1'b1;
            if (!w_diff[DW]) begin
                w_alu_res = w_diff[DW-1:0];
                w_div_bit = 1'b1;
            end
        end
    end

    // AH next value: synchronous clear beats the select code
    always_comb begin
        w_ah_nxt = r_ah;
        if (acc_high_reset_p) begin
            w_ah_nxt = '0;
        end else begin
            case (acc_high_select)
                c_SEL_RIGHT: w_ah_nxt = {(r_mul_last && (acc_low_select == c_SEL_RIGHT)) & r_carry,
                                         r_ah[DW-1:1]};
                c_SEL_LEFT:  w_ah_nxt = {r_ah[DW-2:0],
                                         (acc_low_select == c_SEL_LEFT) & r_al[DW-1]};
                c_SEL_LOAD:  w_ah_nxt = acc_in_select ? bus_in : w_alu_res;
                default:     w_ah_nxt = r_ah;
            endcase
        end
    end

    // AL next value: quotient bit insertion only while AL is holding
    always_comb begin
        w_al_nxt = r_al;
        case (acc_low_select)
            c_SEL_HOLD:  w_al_nxt = w_div_op ? {r_al[DW-1:1], w_div_bit} : r_al;
            c_SEL_RIGHT: w_al_nxt = {(acc_high_select == c_SEL_RIGHT) & r_ah[0], r_al[DW-1:1]};
            c_SEL_LEFT:  w_al_nxt = {r_al[DW-2:0], 1'b0};
            c_SEL_LOAD:  w_al_nxt = r_ah;
            default:     w_al_nxt = r_al;
        endcase
    end

    // Accumulator, carry and multiply-continuation state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ah       <= '0;
            r_al       <= '0;
            r_carry    <= 1'b0;
            r_mul_last <= 1'b0;
        end else begin
            r_ah       <= w_ah_nxt;
            r_al       <= w_al_nxt;
            r_carry    <= w_carry_nxt;
            r_mul_last <= op_mul;
        end
    end

`ifdef ACC_OVF_FLAG_EN
    logic w_alu_ovf;
    logic r_ovf;

    // Signed overflow of the selected add or sub
    always_comb begin
        w_alu_ovf = 1'b0;
        if (op_add) begin
            w_alu_ovf = (r_ah[DW-1] == breg_in[DW-1]) && (w_sum[DW-1] != r_ah[DW-1]);
        end else if (op_sub) begin
            w_alu_ovf = (r_ah[DW-1] != breg_in[DW-1]) && (w_diff[DW-1] != r_ah[DW-1]);
        end
    end

    // Overflow flag captured on add/sub cycles that load AH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (acc_high_reset_p) begin
            r_ovf <= 1'b0;
        end else if ((acc_high_select == c_SEL_LOAD) && (op_add || op_sub)) begin
            r_ovf <= w_alu_ovf;
        end
    end

    assign ovf_flag = r_ovf;
`endif

    assign bus_out   = acc_oen ? r_ah : '0;
    assign bus_oe    = acc_oen;
    assign acc_high  = r_ah;
    assign acc_low   = r_al;
    assign zero_flag = (r_ah == '0);
    assign sign_flag = r_ah[DW-1];

endmodule

`default_nettype wire

// File: tb/tb_acc_datapath.sv
//==============================================================================
// Module      : tb_acc_datapath
// Description : Self-checking bench for acc_datapath: directed scenarios,
//               randomized cycles against an arithmetic reference model,
//               and random multiply/divide sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bus_in, breg_in;
    logic [1:0] hs, ls;
    logic       insel, hrst, oen;
    logic       o_add, o_sub, o_and, o_mul, o_div;
    logic [7:0] bus_out, acc_high, acc_low;
    logic       bus_oe, zero_flag, sign_flag;
`ifdef ACC_OVF_FLAG_EN
    logic       ovf_flag;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ah, m_al, m_carry, m_mul_last, m_ovf;

    always #5 clk = ~clk;

    acc_datapath #(.DW(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus_in           (bus_in),
        .breg_in          (breg_in),
        .acc_high_select  (hs),
        .acc_low_select   (ls),
        .acc_in_select    (insel),
        .acc_high_reset_p (hrst),
        .acc_oen          (oen),
        .op_add           (o_add),
        .op_sub           (o_sub),
        .op_and           (o_and),
        .op_mul           (o_mul),
        .op_div           (o_div),
        .bus_out          (bus_out),
        .bus_oe           (bus_oe),
        .acc_high         (acc_high),
        .acc_low          (acc_low),
        .zero_flag        (zero_flag),
        .sign_flag        (sign_flag)
`ifdef ACC_OVF_FLAG_EN
        ,
        .ovf_flag         (ovf_flag)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ah = 0; m_al = 0; m_carry = 0; m_mul_last = 0; m_ovf = 0;
    endtask

    // One clock of the datapath expressed as integer arithmetic
    task automatic model_step();
        int a, b, al, r, nc, force_bit, nah, nal, ovf, fill;
        a = m_ah; b = breg_in; al = m_al;
        r = a; nc = m_carry; force_bit = -1; ovf = 0;
        if (o_add) begin
            r = (a + b) % 256; nc = (a + b) > 255 ? 1 : 0;
            ovf = ((a >= 128) == (b >= 128) && (r >= 128) != (a >= 128)) ? 1 : 0;
        end else if (o_sub) begin
            r = (a - b + 256) % 256; nc = (a < b) ? 1 : 0;
            ovf = ((a >= 128) != (b >= 128) && (r >= 128) != (a >= 128)) ? 1 : 0;
        end else if (o_and) begin
            r = a & b;
        end else if (o_mul) begin
            if (al % 2 == 1) begin r = (a + b) % 256; nc = (a + b) > 255 ? 1 : 0; end
            else nc = 0;
        end else if (o_div) begin
            if (a >= b) begin r = a - b; force_bit = 1; end
            else force_bit = 0;
        end

        nah = a;
        if (hrst) nah = 0;
        else if (hs == 2'd1) begin
            fill = (m_mul_last == 1 && ls == 2'd1 && m_carry == 1) ? 128 : 0;
            nah = a / 2 + fill;
        end else if (hs == 2'd2) begin
            fill = (ls == 2'd2 && al >= 128) ? 1 : 0;
            nah = (a * 2) % 256 + fill;
        end else if (hs == 2'd3) nah = insel ? int'(bus_in) : r;

        nal = al;
        if (ls == 2'd0) begin
            if (force_bit >= 0) nal = (al / 2) * 2 + force_bit;
        end else if (ls == 2'd1) begin
            fill = (hs == 2'd1 && a % 2 == 1) ? 128 : 0;
            nal = al / 2 + fill;
        end else if (ls == 2'd2) nal = (al * 2) % 256;
        else nal = a;

        if (hrst) m_ovf = 0;
        else if (hs == 2'd3 && (o_add || o_sub)) m_ovf = ovf;

        m_ah = nah; m_al = nal; m_carry = nc; m_mul_last = o_mul;
    endtask

    task automatic idle();
        hs = 2'd0; ls = 2'd0; insel = 1'b0; hrst = 1'b0; oen = 1'b0;
        o_add = 1'b0; o_sub = 1'b0; o_and = 1'b0; o_mul = 1'b0; o_div = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ah"},   acc_high,  m_ah);
        check({tag, ".al"},   acc_low,   m_al);
        check({tag, ".zero"}, zero_flag, (m_ah == 0) ? 1 : 0);
        check({tag, ".sign"}, sign_flag, (m_ah >= 128) ? 1 : 0);
        check({tag, ".bus"},  bus_out,   oen ? m_ah : 0);
        check({tag, ".oe"},   bus_oe,    oen);
`ifdef ACC_OVF_FLAG_EN
        check({tag, ".ovf"},  ovf_flag,  m_ovf);
`endif
    endtask

    task automatic load_ah(input logic [7:0] v);
        idle(); hs = 2'd3; insel = 1'b1; bus_in = v;
        tick();
        idle();
    endtask

    task automatic load_pair(input logic [7:0] h, input logic [7:0] l);
        load_ah(l);
        idle(); ls = 2'd3;
        tick();
        load_ah(h);
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input string tag);
        load_pair(8'h00, a);
        breg_in = b;
        for (int i = 0; i < 8; i++) begin
            idle(); o_mul = 1'b1; hs = 2'd3; tick();
            idle(); hs = 2'd1; ls = 2'd1; tick();
        end
        check({tag, ".prod"}, {acc_high, acc_low}, int'(a) * int'(b));
        check_state(tag);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input string tag);
        load_pair(8'h00, a);
        breg_in = b;
        for (int i = 0; i < 8; i++) begin
            idle(); hs = 2'd2; ls = 2'd2; tick();
            idle(); o_div = 1'b1; hs = 2'd3; tick();
        end
        if (b != 0) begin
            check({tag, ".quot"}, acc_low,  int'(a) / int'(b));
            check({tag, ".rem"},  acc_high, int'(a) % int'(b));
        end else begin
            check({tag, ".quot0"}, acc_low, 8'hFF);
        end
        check_state(tag);
    endtask

    initial begin
        idle();
        bus_in = 8'h00; breg_in = 8'h00;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst");
        reset_n = 1'b1;

        // Asynchronous reset in the middle of a cycle
        load_ah(8'h5A);
        check("pre_rst.ah", acc_high, 8'h5A);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst.ah", acc_high, 8'h00);
        check("arst.al", acc_low, 8'h00);
        check("arst.zero", zero_flag, 1'b1);
        check("arst.bus", bus_out, 8'h00);
        reset_n = 1'b1;

        // Bus load then drive
        load_ah(8'h9C);
        oen = 1'b1;
        #1;
        check("busdrv.bus", bus_out, 8'h9C);
        check("busdrv.oe", bus_oe, 1'b1);
        check("busdrv.sign", sign_flag, 1'b1);
        check("busdrv.zero", zero_flag, 1'b0);
        idle();

        // Add then subtract to zero
        load_ah(8'hF0);
        breg_in = 8'h20; hs = 2'd3; o_add = 1'b1; tick(); idle();
        check("add.ah", acc_high, 8'h10);
        breg_in = 8'h10; hs = 2'd3; o_sub = 1'b1; tick(); idle();
        check("sub.ah", acc_high, 8'h00);
        check("sub.zero", zero_flag, 1'b1);
`ifdef ACC_OVF_FLAG_EN
        load_ah(8'h7F);
        breg_in = 8'h01; hs = 2'd3; o_add = 1'b1; tick(); idle();
        check("ovf.add", ovf_flag, 1'b1);
        hrst = 1'b1; tick(); idle();
        check("ovf.clr", ovf_flag, 1'b0);
`endif

        // Multiply and divide sequences
        run_mul(8'h0D, 8'h0B, "mul13x11");
        check("mul13x11.const", {acc_high, acc_low}, 16'h008F);
        run_mul(8'hFF, 8'hFF, "mulFFxFF");
        check("mulFFxFF.const", {acc_high, acc_low}, 16'hFE01);
        run_div(8'd100, 8'd7, "div100_7");
        check("div100_7.const", {acc_high, acc_low}, 16'h020E);
        run_div(8'd100, 8'd0, "div_by0");

        // Shifts, AL load and synchronous AH clear
        load_pair(8'h81, 8'h01);
        hs = 2'd2; ls = 2'd2; tick(); idle();
        check("shl.ah", acc_high, 8'h02);
        check("shl.al", acc_low, 8'h02);
        hs = 2'd1; ls = 2'd1; tick(); idle();
        check("shr.ah", acc_high, 8'h01);
        check("shr.al", acc_low, 8'h01);
        load_ah(8'hA5);
        ls = 2'd3; hs = 2'd3; insel = 1'b1; bus_in = 8'h3C; tick(); idle();
        check("alload.al", acc_low, 8'hA5);
        check("alload.ah", acc_high, 8'h3C);
        hs = 2'd3; insel = 1'b1; bus_in = 8'h77; hrst = 1'b1; tick(); idle();
        check("hrst.ah", acc_high, 8'h00);
        check_state("hrst");

        // Randomized single cycles against the reference model
        for (int n = 0; n < 400; n++) begin
            int k;
            idle();
            hs      = 2'($urandom_range(0, 3));
            ls      = 2'($urandom_range(0, 3));
            insel   = 1'($urandom_range(0, 1));
            hrst    = ($urandom_range(0, 7) == 0);
            oen     = 1'($urandom_range(0, 1));
            bus_in  = 8'($urandom);
            breg_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            k = $urandom_range(0, 7);
            o_add = (k == 0); o_sub = (k == 1); o_and = (k == 2);
            o_mul = (k == 3); o_div = (k == 4);
            tick();
            check_state("rand");
        end

        // Randomized multiply/divide sequences
        for (int n = 0; n < 6; n++) begin
            run_mul(8'($urandom), 8'($urandom), "rmul");
            run_div(8'($urandom), 8'($urandom_range(1, 255)), "rdiv");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
